// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO and also handles MTHI/MTLO.
// Optional build macro MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier is zero.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             mf_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   acc_r;      // product, or {remainder, quotient/dividend}
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;   // multiplier, or divisor
  logic                 is_div_r;
  logic                 res_neg_r;
  logic                 rem_neg_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 signed_s;
  logic                 rs_neg_s;
  logic                 rt_neg_s;
  logic                 rt_zero_s;
  logic [WIDTH-1:0]     rs_mag_s;
  logic [WIDTH-1:0]     rt_mag_s;
  logic [2*WIDTH-1:0]   mul_acc_s;
  logic [WIDTH:0]       trial_s;
  logic [2*WIDTH-1:0]   div_acc_s;
  logic                 last_iter_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;

  // Operand decode: signedness and magnitudes for the accept edge
  always_comb begin
    signed_s  = (op_i == 3'd0) || (op_i == 3'd2);
    rs_neg_s  = signed_s & rs_data_i[WIDTH-1];
    rt_neg_s  = signed_s & rt_data_i[WIDTH-1];
    rs_mag_s  = abs_val(rs_data_i, rs_neg_s);
    rt_mag_s  = abs_val(rt_data_i, rt_neg_s);
    rt_zero_s = (rt_data_i == {WIDTH{1'b0}});
  end

  // One shift-add / restoring-subtract step plus the sign fixup of the final result
  always_comb begin
    mul_acc_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    trial_s   = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, mplier_r};
    if (trial_s[WIDTH]) begin
      div_acc_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end else begin
      div_acc_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
    if (is_div_r) begin
      last_iter_s = (cnt_r == CNT_ZERO);
    end else begin
      last_iter_s = (cnt_r == CNT_ZERO) ||
                    (EARLY_OUT && (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}}));
    end
    prod_s = res_neg_r ? -acc_r : acc_r;
    quo_s  = res_neg_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s  = rem_neg_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
  end

  // Sequencer FSM, operand latches and HI/LO registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      acc_r     <= {(2*WIDTH){1'b0}};
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            cnt_r   <= CW'(WIDTH-1);
            mcand_r <= {{WIDTH{1'b0}}, rs_mag_s};
            case (op_i)
              3'd0, 3'd1: begin
                acc_r     <= {(2*WIDTH){1'b0}};
                mplier_r  <= rt_mag_s;
                is_div_r  <= 1'b0;
                res_neg_r <= rs_neg_s ^ rt_neg_s;
                rem_neg_r <= 1'b0;
                busy_r    <= 1'b1;
                state_r   <= (EARLY_OUT && (rt_mag_s == {WIDTH{1'b0}})) ? FIX : CALC;
              end
              3'd2, 3'd3: begin
                is_div_r <= 1'b1;
                busy_r   <= 1'b1;
                state_r  <= CALC;
                // Divide by zero runs on the raw dividend: quotient all ones, remainder = rs
                if (rt_zero_s) begin
                  acc_r     <= {{WIDTH{1'b0}}, rs_data_i};
                  mplier_r  <= {WIDTH{1'b0}};
                  res_neg_r <= 1'b0;
                  rem_neg_r <= 1'b0;
                end else begin
                  acc_r     <= {{WIDTH{1'b0}}, rs_mag_s};
                  mplier_r  <= rt_mag_s;
                  res_neg_r <= rs_neg_s ^ rt_neg_s;
                  rem_neg_r <= rs_neg_s;
                end
              end
              3'd4:    hi_r <= rs_data_i;
              3'd5:    lo_r <= rs_data_i;
              default: begin end
            endcase
          end
        end
        CALC: begin
          if (is_div_r) begin
            acc_r <= div_acc_s;
          end else begin
            acc_r    <= mul_acc_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          end
          if (last_iter_s) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        FIX: begin
          if (is_div_r) begin
            hi_r <= rem_s;
            lo_r <= quo_s;
          end else begin
            hi_r <= prod_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_s[WIDTH-1:0];
          end
          cnt_r   <= CNT_ZERO;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign hi_o    = hi_r;
  assign lo_o    = lo_r;
  assign busy_o  = busy_r;
  assign done_o  = done_r;
  assign stall_o = busy_r & (start_i | mf_i);

endmodule
